// File: rtl/object_motion_engine_if.sv
// Command/status bundle between the pattern sequencer (master) and one object motion engine (slave).
// The acceleration fields exist only when OBJECT_MOTION_ACCEL_EN is defined.
interface object_motion_engine_if #(
  parameter int COORD_W = 10,
  parameter int SPEED_W = 8,
  parameter int LIFE_W  = 8
);
  logic                      step_tick;
  logic                      second_tick;
  logic                      spawn;
  logic                      kill;
  logic        [COORD_W-1:0] spawn_pos_x;
  logic        [COORD_W-1:0] spawn_pos_y;
  logic signed [SPEED_W-1:0] spawn_vel_x;
  logic signed [SPEED_W-1:0] spawn_vel_y;
`ifdef OBJECT_MOTION_ACCEL_EN
  logic signed [SPEED_W-1:0] spawn_acc_x;
  logic signed [SPEED_W-1:0] spawn_acc_y;
`endif
  logic        [COORD_W-1:0] spawn_w;
  logic        [COORD_W-1:0] spawn_h;
  logic        [LIFE_W-1:0]  spawn_lifetime;
  logic        [1:0]         spawn_mode;
  logic        [COORD_W-1:0] box_x1;
  logic        [COORD_W-1:0] box_y1;
  logic        [COORD_W-1:0] box_x2;
  logic        [COORD_W-1:0] box_y2;
  logic        [COORD_W-1:0] obj_pos_x;
  logic        [COORD_W-1:0] obj_pos_y;
  logic        [COORD_W-1:0] obj_w;
  logic        [COORD_W-1:0] obj_h;
  logic                      obj_active;
  logic                      obj_updated;
  logic                      destroy_pulse;
  logic        [1:0]         destroy_cause;

  modport master (
`ifdef OBJECT_MOTION_ACCEL_EN
    output spawn_acc_x, spawn_acc_y,
`endif
    output step_tick, second_tick, spawn, kill,
    output spawn_pos_x, spawn_pos_y, spawn_vel_x, spawn_vel_y,
    output spawn_w, spawn_h, spawn_lifetime, spawn_mode,
    output box_x1, box_y1, box_x2, box_y2,
    input  obj_pos_x, obj_pos_y, obj_w, obj_h,
    input  obj_active, obj_updated, destroy_pulse, destroy_cause
  );

  modport slave (
`ifdef OBJECT_MOTION_ACCEL_EN
    input  spawn_acc_x, spawn_acc_y,
`endif
    input  step_tick, second_tick, spawn, kill,
    input  spawn_pos_x, spawn_pos_y, spawn_vel_x, spawn_vel_y,
    input  spawn_w, spawn_h, spawn_lifetime, spawn_mode,
    input  box_x1, box_y1, box_x2, box_y2,
    output obj_pos_x, obj_pos_y, obj_w, obj_h,
    output obj_active, obj_updated, destroy_pulse, destroy_cause
  );
endinterface

// File: rtl/object_motion_engine.sv
// Single-object motion controller: spawn load, fixed-point stepping, lifetime and boundary handling.
// Define OBJECT_MOTION_ACCEL_EN to add per-axis saturating acceleration.
module object_motion_engine #(
  parameter int COORD_W   = 10,
  parameter int FRAC_BITS = 3,
  parameter int SPEED_W   = 8,
  parameter int LIFE_W    = 8,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input logic                   clk_object_control,
  input logic                   reset,
  object_motion_engine_if.slave bus
);
  // Internal position keeps a sign bit and one overflow bit above the pixel range.
  localparam int PW = COORD_W + FRAC_BITS + 2;
  localparam int IW = COORD_W + 2;
  localparam int CW = COORD_W + 3;

  localparam logic [1:0] CAUSE_LIFE   = 2'd1;
  localparam logic [1:0] CAUSE_SCREEN = 2'd2;
  localparam logic [1:0] CAUSE_BOX    = 2'd3;
  localparam logic [1:0] MODE_SCREEN  = 2'd1;
  localparam logic [1:0] MODE_BOX     = 2'd2;
  localparam logic [1:0] MODE_BOUNCE  = 2'd3;

  localparam logic signed [CW-1:0] ZERO_C  = '0;
  localparam logic signed [CW-1:0] SCR_W_C = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SCR_H_C = CW'(SCREEN_H);

  typedef enum logic {FREE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                    state_p1;
  logic signed [PW-1:0]      pos_x_p1, pos_y_p1;
  logic signed [SPEED_W-1:0] vel_x_p1, vel_y_p1;
  logic        [COORD_W-1:0] w_p1, h_p1;
  logic        [COORD_W-1:0] bx1_p1, by1_p1, bx2_p1, by2_p1;
  logic        [LIFE_W-1:0]  life_p1;
  logic        [1:0]         mode_p1;
  logic        [1:0]         cause_p1;
  logic                      vld_p1;
  logic                      destroy_p1;
`ifdef OBJECT_MOTION_ACCEL_EN
  logic signed [SPEED_W-1:0] acc_x_p1, acc_y_p1;
`endif

  function automatic logic signed [PW-1:0] sext_vel(input logic signed [SPEED_W-1:0] v);
    sext_vel = {{(PW-SPEED_W){v[SPEED_W-1]}}, v};
  endfunction

  function automatic logic signed [CW-1:0] int_of(input logic signed [PW-1:0] p);
    int_of = {p[PW-1], p[PW-1:FRAC_BITS]};
  endfunction

  function automatic logic signed [CW-1:0] widen(input logic [COORD_W-1:0] c);
    widen = {3'b000, c};
  endfunction

  function automatic logic signed [PW-1:0] fix_of(input logic signed [IW-1:0] i);
    fix_of = {i, {FRAC_BITS{1'b0}}};
  endfunction

  // Clamp to the visible coordinate range: negatives to 0, overflow to all ones.
  function automatic logic [COORD_W-1:0] sat_coord(input logic signed [PW-1:0] p);
    logic [IW-1:0] ip;
    ip = p[PW-1:FRAC_BITS];
    if (ip[IW-1])      sat_coord = '0;
    else if (ip[IW-2]) sat_coord = '1;
    else               sat_coord = ip[COORD_W-1:0];
  endfunction

  function automatic logic signed [SPEED_W-1:0] neg_sat(input logic signed [SPEED_W-1:0] v);
    if (v == {1'b1, {(SPEED_W-1){1'b0}}}) neg_sat = {1'b0, {(SPEED_W-1){1'b1}}};
    else                                  neg_sat = -v;
  endfunction

`ifdef OBJECT_MOTION_ACCEL_EN
  function automatic logic signed [SPEED_W-1:0] add_sat(input logic signed [SPEED_W-1:0] a,
                                                        input logic signed [SPEED_W-1:0] b);
    logic signed [SPEED_W:0] s;
    s = {a[SPEED_W-1], a} + {b[SPEED_W-1], b};
    if (s[SPEED_W] != s[SPEED_W-1])
      add_sat = s[SPEED_W] ? {1'b1, {(SPEED_W-1){1'b0}}} : {1'b0, {(SPEED_W-1){1'b1}}};
    else
      add_sat = s[SPEED_W-1:0];
  endfunction
`endif

  // Reflect off the low edge first, then the high edge, snapping onto the wall.
  function automatic void bounce(input  logic signed [PW-1:0]      nxt,
                                 input  logic signed [SPEED_W-1:0] vel,
                                 input  logic        [COORD_W-1:0] lo,
                                 input  logic        [COORD_W-1:0] hi,
                                 input  logic        [COORD_W-1:0] size,
                                 output logic signed [PW-1:0]      p,
                                 output logic signed [SPEED_W-1:0] v);
    logic signed [CW-1:0] ni;
    logic signed [IW-1:0] lim;
    ni  = int_of(nxt);
    lim = {2'b00, hi} - {2'b00, size};
    p   = nxt;
    v   = vel;
    if (ni < widen(lo)) begin
      p = fix_of({2'b00, lo});
      v = neg_sat(vel);
    end else if (ni + widen(size) > widen(hi)) begin
      p = fix_of(lim);
      v = neg_sat(vel);
    end
  endfunction

  logic signed [PW-1:0]      nxt_x, nxt_y, bnc_pos_x, bnc_pos_y;
  logic signed [SPEED_W-1:0] bnc_vel_x, bnc_vel_y, base_vel_x, base_vel_y;
  logic signed [SPEED_W-1:0] new_vel_x, new_vel_y;
  logic signed [CW-1:0]      ni_x, ni_y, end_x, end_y;
  logic                      screen_out, box_out, life_expire, active;

  always_comb begin
    nxt_x = pos_x_p1 + sext_vel(vel_x_p1);
    nxt_y = pos_y_p1 + sext_vel(vel_y_p1);
    ni_x  = int_of(nxt_x);
    ni_y  = int_of(nxt_y);
    end_x = ni_x + widen(w_p1);
    end_y = ni_y + widen(h_p1);
    screen_out = (ni_x >= SCR_W_C) || (end_x <= ZERO_C) ||
                 (ni_y >= SCR_H_C) || (end_y <= ZERO_C);
    box_out    = (ni_x >= widen(bx2_p1)) || (end_x <= widen(bx1_p1)) ||
                 (ni_y >= widen(by2_p1)) || (end_y <= widen(by1_p1));
    bounce(nxt_x, vel_x_p1, bx1_p1, bx2_p1, w_p1, bnc_pos_x, bnc_vel_x);
    bounce(nxt_y, vel_y_p1, by1_p1, by2_p1, h_p1, bnc_pos_y, bnc_vel_y);
    base_vel_x = (mode_p1 == MODE_BOUNCE) ? bnc_vel_x : vel_x_p1;
    base_vel_y = (mode_p1 == MODE_BOUNCE) ? bnc_vel_y : vel_y_p1;
`ifdef OBJECT_MOTION_ACCEL_EN
    new_vel_x = add_sat(base_vel_x, acc_x_p1);
    new_vel_y = add_sat(base_vel_y, acc_y_p1);
`else
    new_vel_x = base_vel_x;
    new_vel_y = base_vel_y;
`endif
    life_expire = bus.second_tick && (life_p1 == LIFE_W'(1));
  end

  // Stage p1: state, motion registers and event pulses.
  always_ff @(posedge clk_object_control or posedge reset) begin
    if (reset) begin
      state_p1   <= FREE;
      pos_x_p1   <= '0;
      pos_y_p1   <= '0;
      vel_x_p1   <= '0;
      vel_y_p1   <= '0;
      w_p1       <= '0;
      h_p1       <= '0;
      bx1_p1     <= '0;
      by1_p1     <= '0;
      bx2_p1     <= '0;
      by2_p1     <= '0;
      life_p1    <= '0;
      mode_p1    <= '0;
      cause_p1   <= '0;
      vld_p1     <= 1'b0;
      destroy_p1 <= 1'b0;
`ifdef OBJECT_MOTION_ACCEL_EN
      acc_x_p1   <= '0;
      acc_y_p1   <= '0;
`endif
    end else begin
      vld_p1     <= 1'b0;
      destroy_p1 <= 1'b0;
      if (bus.spawn) begin
        state_p1 <= ACTIVE;
        pos_x_p1 <= fix_of({2'b00, bus.spawn_pos_x});
        pos_y_p1 <= fix_of({2'b00, bus.spawn_pos_y});
        vel_x_p1 <= bus.spawn_vel_x;
        vel_y_p1 <= bus.spawn_vel_y;
        w_p1     <= bus.spawn_w;
        h_p1     <= bus.spawn_h;
        bx1_p1   <= bus.box_x1;
        by1_p1   <= bus.box_y1;
        bx2_p1   <= bus.box_x2;
        by2_p1   <= bus.box_y2;
        life_p1  <= bus.spawn_lifetime;
        mode_p1  <= bus.spawn_mode;
        vld_p1   <= 1'b1;
`ifdef OBJECT_MOTION_ACCEL_EN
        acc_x_p1 <= bus.spawn_acc_x;
        acc_y_p1 <= bus.spawn_acc_y;
`endif
      end else if (bus.kill) begin
        state_p1 <= FREE;
      end else if (state_p1 == ACTIVE) begin
        if (life_expire) begin
          state_p1   <= FREE;
          life_p1    <= '0;
          destroy_p1 <= 1'b1;
          cause_p1   <= CAUSE_LIFE;
        end else begin
          if (bus.second_tick && (life_p1 != '0))
            life_p1 <= life_p1 - 1'b1;
          if (bus.step_tick) begin
            if ((mode_p1 == MODE_SCREEN) && screen_out) begin
              state_p1   <= FREE;
              destroy_p1 <= 1'b1;
              cause_p1   <= CAUSE_SCREEN;
            end else if ((mode_p1 == MODE_BOX) && box_out) begin
              state_p1   <= FREE;
              destroy_p1 <= 1'b1;
              cause_p1   <= CAUSE_BOX;
            end else begin
              pos_x_p1 <= (mode_p1 == MODE_BOUNCE) ? bnc_pos_x : nxt_x;
              pos_y_p1 <= (mode_p1 == MODE_BOUNCE) ? bnc_pos_y : nxt_y;
              vel_x_p1 <= new_vel_x;
              vel_y_p1 <= new_vel_y;
              vld_p1   <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign active            = (state_p1 == ACTIVE);
  assign bus.obj_active    = active;
  assign bus.obj_pos_x     = active ? sat_coord(pos_x_p1) : '0;
  assign bus.obj_pos_y     = active ? sat_coord(pos_y_p1) : '0;
  assign bus.obj_w         = active ? w_p1 : '0;
  assign bus.obj_h         = active ? h_p1 : '0;
  assign bus.obj_updated   = vld_p1;
  assign bus.destroy_pulse = destroy_p1;
  assign bus.destroy_cause = cause_p1;
endmodule

// File: tb/tb_object_motion_engine.sv
// Directed bench for object_motion_engine: free-run, screen/box exit, bounce, lifetime, respawn, kill, reset.
module tb_object_motion_engine;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  object_motion_engine_if bus ();

  object_motion_engine dut (
    .clk_object_control (clk),
    .reset              (reset),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.step_tick      = 1'b0;
    bus.second_tick    = 1'b0;
    bus.spawn          = 1'b0;
    bus.kill           = 1'b0;
    bus.spawn_pos_x    = '0;
    bus.spawn_pos_y    = '0;
    bus.spawn_vel_x    = '0;
    bus.spawn_vel_y    = '0;
    bus.spawn_w        = '0;
    bus.spawn_h        = '0;
    bus.spawn_lifetime = '0;
    bus.spawn_mode     = '0;
    bus.box_x1         = '0;
    bus.box_y1         = '0;
    bus.box_x2         = '0;
    bus.box_y2         = '0;
`ifdef OBJECT_MOTION_ACCEL_EN
    bus.spawn_acc_x    = '0;
    bus.spawn_acc_y    = '0;
`endif
  endtask

  task automatic spawn_obj(input int x, input int y, input int vx, input int vy,
                           input int w, input int h, input int life, input int mode,
                           input int bx1, input int by1, input int bx2, input int by2,
                           input bit with_step);
    bus.spawn_pos_x    = 10'(x);
    bus.spawn_pos_y    = 10'(y);
    bus.spawn_vel_x    = 8'(vx);
    bus.spawn_vel_y    = 8'(vy);
    bus.spawn_w        = 10'(w);
    bus.spawn_h        = 10'(h);
    bus.spawn_lifetime = 8'(life);
    bus.spawn_mode     = 2'(mode);
    bus.box_x1         = 10'(bx1);
    bus.box_y1         = 10'(by1);
    bus.box_x2         = 10'(bx2);
    bus.box_y2         = 10'(by2);
    bus.spawn          = 1'b1;
    bus.step_tick      = with_step;
    @(posedge clk); #1;
    bus.spawn          = 1'b0;
    bus.step_tick      = 1'b0;
  endtask

  task automatic pulse(input bit stp, input bit sec, input bit kil);
    bus.step_tick   = stp;
    bus.second_tick = sec;
    bus.kill        = kil;
    @(posedge clk); #1;
    bus.step_tick   = 1'b0;
    bus.second_tick = 1'b0;
    bus.kill        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    total++; if (bus.obj_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %0d want 0", bus.obj_active); end
    total++; if (bus.obj_pos_x !== 10'd0) begin bad++; $display("FAIL reset_pos_x: got %0d want 0", bus.obj_pos_x); end
    total++; if (bus.obj_w !== 10'd0) begin bad++; $display("FAIL reset_w: got %0d want 0", bus.obj_w); end
    total++; if (bus.obj_updated !== 1'b0) begin bad++; $display("FAIL reset_updated: got %0d want 0", bus.obj_updated); end
    total++; if (bus.destroy_pulse !== 1'b0) begin bad++; $display("FAIL reset_destroy: got %0d want 0", bus.destroy_pulse); end
    total++; if (bus.destroy_cause !== 2'd0) begin bad++; $display("FAIL reset_cause: got %0d want 0", bus.destroy_cause); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_free_run();
    int exp_x[4] = '{101, 103, 104, 106};
    spawn_obj(100, 50, 12, 0, 16, 16, 0, 0, 0, 0, 0, 0, 1'b0);
    total++; if (bus.obj_active !== 1'b1) begin bad++; $display("FAIL spawn_active: got %0d want 1", bus.obj_active); end
    total++; if (bus.obj_updated !== 1'b1) begin bad++; $display("FAIL spawn_updated: got %0d want 1", bus.obj_updated); end
    total++; if (bus.obj_pos_x !== 10'd100) begin bad++; $display("FAIL spawn_pos_x: got %0d want 100", bus.obj_pos_x); end
    total++; if (bus.obj_w !== 10'd16) begin bad++; $display("FAIL spawn_w: got %0d want 16", bus.obj_w); end
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      total++; if (bus.obj_pos_x !== 10'(exp_x[i])) begin bad++; $display("FAIL free_run_x step%0d: got %0d want %0d", i, bus.obj_pos_x, exp_x[i]); end
      total++; if (bus.obj_pos_y !== 10'd50) begin bad++; $display("FAIL free_run_y step%0d: got %0d want 50", i, bus.obj_pos_y); end
      total++; if (bus.obj_updated !== 1'b1) begin bad++; $display("FAIL free_run_updated step%0d: got %0d want 1", i, bus.obj_updated); end
    end
    pulse(1'b0, 1'b0, 1'b0);
    total++; if (bus.obj_updated !== 1'b0) begin bad++; $display("FAIL idle_updated: got %0d want 0", bus.obj_updated); end
    total++; if (bus.obj_pos_x !== 10'd106) begin bad++; $display("FAIL idle_hold_x: got %0d want 106", bus.obj_pos_x); end
  endtask

  task automatic test_screen_exit();
    spawn_obj(636, 100, 32, 0, 8, 8, 0, 1, 0, 0, 0, 0, 1'b0);
    total++; if (bus.obj_pos_x !== 10'd636) begin bad++; $display("FAIL screen_spawn_x: got %0d want 636", bus.obj_pos_x); end
    pulse(1'b1, 1'b0, 1'b0);
    total++; if (bus.obj_active !== 1'b0) begin bad++; $display("FAIL screen_active: got %0d want 0", bus.obj_active); end
    total++; if (bus.destroy_pulse !== 1'b1) begin bad++; $display("FAIL screen_pulse: got %0d want 1", bus.destroy_pulse); end
    total++; if (bus.destroy_cause !== 2'd2) begin bad++; $display("FAIL screen_cause: got %0d want 2", bus.destroy_cause); end
    total++; if (bus.obj_pos_x !== 10'd0) begin bad++; $display("FAIL screen_pos_x: got %0d want 0", bus.obj_pos_x); end
    total++; if (bus.obj_w !== 10'd0) begin bad++; $display("FAIL screen_w: got %0d want 0", bus.obj_w); end
    pulse(1'b0, 1'b0, 1'b0);
    total++; if (bus.destroy_pulse !== 1'b0) begin bad++; $display("FAIL screen_pulse_len: got %0d want 0", bus.destroy_pulse); end
    total++; if (bus.destroy_cause !== 2'd2) begin bad++; $display("FAIL screen_cause_hold: got %0d want 2", bus.destroy_cause); end
  endtask

  task automatic test_bounce();
    int exp_x[3] = '{192, 192, 190};
    spawn_obj(190, 100, 16, 0, 8, 8, 0, 3, 100, 50, 200, 300, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      total++; if (bus.obj_pos_x !== 10'(exp_x[i])) begin bad++; $display("FAIL bounce_x step%0d: got %0d want %0d", i, bus.obj_pos_x, exp_x[i]); end
      total++; if (bus.obj_active !== 1'b1) begin bad++; $display("FAIL bounce_active step%0d: got %0d want 1", i, bus.obj_active); end
    end
    total++; if (bus.obj_pos_y !== 10'd100) begin bad++; $display("FAIL bounce_y: got %0d want 100", bus.obj_pos_y); end
  endtask

  task automatic test_box_exit();
    spawn_obj(192, 100, 32, 0, 8, 8, 0, 2, 100, 50, 200, 300, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    total++; if (bus.obj_pos_x !== 10'd196) begin bad++; $display("FAIL box_step_x: got %0d want 196", bus.obj_pos_x); end
    total++; if (bus.obj_active !== 1'b1) begin bad++; $display("FAIL box_still_active: got %0d want 1", bus.obj_active); end
    pulse(1'b1, 1'b0, 1'b0);
    total++; if (bus.obj_active !== 1'b0) begin bad++; $display("FAIL box_exit_active: got %0d want 0", bus.obj_active); end
    total++; if (bus.destroy_pulse !== 1'b1) begin bad++; $display("FAIL box_exit_pulse: got %0d want 1", bus.destroy_pulse); end
    total++; if (bus.destroy_cause !== 2'd3) begin bad++; $display("FAIL box_exit_cause: got %0d want 3", bus.destroy_cause); end
  endtask

  task automatic test_lifetime();
    spawn_obj(300, 200, 8, 0, 8, 8, 2, 0, 0, 0, 0, 0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    total++; if (bus.obj_active !== 1'b1) begin bad++; $display("FAIL life_tick1_active: got %0d want 1", bus.obj_active); end
    total++; if (bus.destroy_pulse !== 1'b0) begin bad++; $display("FAIL life_tick1_pulse: got %0d want 0", bus.destroy_pulse); end
    total++; if (bus.obj_pos_x !== 10'd300) begin bad++; $display("FAIL life_tick1_x: got %0d want 300", bus.obj_pos_x); end
    pulse(1'b1, 1'b1, 1'b0);
    total++; if (bus.obj_active !== 1'b0) begin bad++; $display("FAIL life_tick2_active: got %0d want 0", bus.obj_active); end
    total++; if (bus.destroy_pulse !== 1'b1) begin bad++; $display("FAIL life_tick2_pulse: got %0d want 1", bus.destroy_pulse); end
    total++; if (bus.destroy_cause !== 2'd1) begin bad++; $display("FAIL life_tick2_cause: got %0d want 1", bus.destroy_cause); end
    total++; if (bus.obj_updated !== 1'b0) begin bad++; $display("FAIL life_tick2_updated: got %0d want 0", bus.obj_updated); end
    pulse(1'b0, 1'b1, 1'b0);
    total++; if (bus.destroy_pulse !== 1'b0) begin bad++; $display("FAIL life_tick3_pulse: got %0d want 0", bus.destroy_pulse); end
    total++; if (bus.obj_active !== 1'b0) begin bad++; $display("FAIL life_tick3_active: got %0d want 0", bus.obj_active); end
  endtask

  task automatic test_respawn_kill();
    spawn_obj(100, 60, 8, 0, 4, 4, 0, 0, 0, 0, 0, 0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    total++; if (bus.obj_pos_x !== 10'd101) begin bad++; $display("FAIL pre_respawn_x: got %0d want 101", bus.obj_pos_x); end
    spawn_obj(300, 70, 8, 0, 4, 4, 0, 0, 0, 0, 0, 0, 1'b0);
    total++; if (bus.obj_pos_x !== 10'd300) begin bad++; $display("FAIL respawn_x: got %0d want 300", bus.obj_pos_x); end
    total++; if (bus.destroy_pulse !== 1'b0) begin bad++; $display("FAIL respawn_pulse: got %0d want 0", bus.destroy_pulse); end
    total++; if (bus.obj_updated !== 1'b1) begin bad++; $display("FAIL respawn_updated: got %0d want 1", bus.obj_updated); end
    spawn_obj(400, 80, 8, 0, 4, 4, 0, 0, 0, 0, 0, 0, 1'b1);
    total++; if (bus.obj_pos_x !== 10'd400) begin bad++; $display("FAIL spawn_step_x: got %0d want 400", bus.obj_pos_x); end
    pulse(1'b0, 1'b0, 1'b1);
    total++; if (bus.obj_active !== 1'b0) begin bad++; $display("FAIL kill_active: got %0d want 0", bus.obj_active); end
    total++; if (bus.destroy_pulse !== 1'b0) begin bad++; $display("FAIL kill_pulse: got %0d want 0", bus.destroy_pulse); end
    total++; if (bus.obj_pos_x !== 10'd0) begin bad++; $display("FAIL kill_pos_x: got %0d want 0", bus.obj_pos_x); end
    pulse(1'b1, 1'b0, 1'b0);
    total++; if (bus.obj_updated !== 1'b0) begin bad++; $display("FAIL free_step_updated: got %0d want 0", bus.obj_updated); end
    total++; if (bus.obj_active !== 1'b0) begin bad++; $display("FAIL free_step_active: got %0d want 0", bus.obj_active); end
  endtask

  task automatic test_async_reset_mid_motion();
    spawn_obj(200, 90, 16, 0, 4, 4, 0, 0, 0, 0, 0, 0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    total++; if (bus.obj_pos_x !== 10'd202) begin bad++; $display("FAIL pre_reset_x: got %0d want 202", bus.obj_pos_x); end
    #2 reset = 1'b1;
    #1;
    total++; if (bus.obj_active !== 1'b0) begin bad++; $display("FAIL async_reset_active: got %0d want 0", bus.obj_active); end
    total++; if (bus.obj_pos_x !== 10'd0) begin bad++; $display("FAIL async_reset_pos_x: got %0d want 0", bus.obj_pos_x); end
    total++; if (bus.destroy_pulse !== 1'b0) begin bad++; $display("FAIL async_reset_pulse: got %0d want 0", bus.destroy_pulse); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b0;
    total = 0;
    bad   = 0;
    clear_inputs();
    test_reset();
    test_free_run();
    test_screen_exit();
    test_bounce();
    test_box_exit();
    test_lifetime();
    test_respawn_kill();
    test_async_reset_mid_motion();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
